// File: rtl/mul_sched.sv
// Round-robin scheduler sharing one multiplier among NUM_REQ requesters; grant and operands are combinational.
// Result appears LATENCY+1 cycles after the transfer cycle; responses are never back-pressured, only hold stalls grants.
module mul_sched #(
    parameter int WIDTH   = 8,
    parameter int NUM_REQ = 4,
    parameter int LATENCY = 1,
    localparam int IDW    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_REQ-1:0]       req_valid,
    output logic [NUM_REQ-1:0]       req_ready,
    input  logic [NUM_REQ*WIDTH-1:0] req_a,
    input  logic [NUM_REQ*WIDTH-1:0] req_b,
    input  logic [NUM_REQ-1:0]       req_unsign,
    input  logic                     hold,
    output logic [WIDTH-1:0]         mul_a,
    output logic [WIDTH-1:0]         mul_b,
    output logic                     mul_unsign,
    input  logic [WIDTH-1:0]         mul_lower,
    input  logic [WIDTH-1:0]         mul_upper,
    output logic                     rsp_valid,
    output logic [IDW-1:0]           rsp_id,
    output logic [WIDTH-1:0]         rsp_lower,
    output logic [WIDTH-1:0]         rsp_upper,
    output logic                     idle
);

    logic [IDW-1:0]   ptr_q, ptr_d;
    logic [IDW-1:0]   gnt_id;
    logic [IDW-1:0]   idx;
    logic             found;
    logic             xfer;
    logic             tail_vld;
    logic [IDW-1:0]   tail_id;
    logic             pipe_busy;
    logic             rsp_valid_q;
    logic [IDW-1:0]   rsp_id_q;
    logic [WIDTH-1:0] rsp_lower_q, rsp_upper_q;

    // First valid requester at or above ptr, wrapping modulo NUM_REQ.
    always_comb begin
        found  = 1'b0;
        gnt_id = '0;
        idx    = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = IDW'((int'(ptr_q) + k) % NUM_REQ);
            if (!found && req_valid[idx]) begin
                found  = 1'b1;
                gnt_id = idx;
            end
        end
    end

    assign xfer = found & ~hold & rst_n;

    always_comb begin
        req_ready  = '0;
        mul_a      = '0;
        mul_b      = '0;
        mul_unsign = 1'b0;
        ptr_d      = ptr_q;
        if (xfer) begin
            req_ready[gnt_id] = 1'b1;
            mul_a      = req_a[gnt_id*WIDTH +: WIDTH];
            mul_b      = req_b[gnt_id*WIDTH +: WIDTH];
            mul_unsign = req_unsign[gnt_id];
            ptr_d      = (gnt_id == IDW'(NUM_REQ - 1)) ? '0 : gnt_id + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    // With a combinational multiplier the current transfer is itself the tail.
    generate
        if (LATENCY == 0) begin : g_nopipe
            assign tail_vld  = xfer;
            assign tail_id   = gnt_id;
            assign pipe_busy = 1'b0;
        end else begin : g_pipe
            logic [LATENCY-1:0]          vld_q;
            logic [LATENCY-1:0][IDW-1:0] id_q;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    vld_q <= '0;
                    id_q  <= '0;
                end else begin
                    vld_q[0] <= xfer;
                    id_q[0]  <= gnt_id;
                    for (int i = 1; i < LATENCY; i++) begin
                        vld_q[i] <= vld_q[i-1];
                        id_q[i]  <= id_q[i-1];
                    end
                end
            end

            assign tail_vld  = vld_q[LATENCY-1];
            assign tail_id   = id_q[LATENCY-1];
            assign pipe_busy = |vld_q;
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= '0;
            rsp_lower_q <= '0;
            rsp_upper_q <= '0;
        end else begin
            rsp_valid_q <= tail_vld;
            if (tail_vld) begin
                rsp_id_q    <= tail_id;
                rsp_lower_q <= mul_lower;
                rsp_upper_q <= mul_upper;
            end
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_id    = rsp_id_q;
    assign rsp_lower = rsp_lower_q;
    assign rsp_upper = rsp_upper_q;
    assign idle      = ~pipe_busy & ~rsp_valid_q & ~xfer;

endmodule
